// File: rtl/instruction_sequencer_pkg.sv
// sequencer_pkg: shared constants and types for the instruction sequencer.
//   PHASE_W    - width of the phase/state code
//   OP_*       - opcode field values taken from ir[7:6]
//   state_t    - FSM state encoding, which is also the exported phase code
//   levels_t   - decoded datapath select levels
package sequencer_pkg;

  localparam int PHASE_W = 3;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_BEQ   = 2'b11;

  typedef enum logic [PHASE_W-1:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5
  } state_t;

  typedef struct packed {
    logic reg_dst;
    logic alu_src;
    logic mem_to_reg;
    logic alu_op;
  } levels_t;

endpackage

// File: rtl/instruction_sequencer_if.sv
// instruction_sequencer_if: groups the sequencer's control-side signals.
//   master modport : drives step/run/instruction/alu_zero, observes the rest
//   slave modport  : the sequencer itself
//   Inputs  : step, run, instruction[7:0], alu_zero
//   Outputs : ir[7:0], phase, busy, seven one-cycle strobes,
//             four decoded levels, retired[RETIRE_W-1:0]
interface instruction_sequencer_if
  import sequencer_pkg::*;
#(
  parameter int RETIRE_W = 8
);
  logic                step;
  logic                run;
  logic [7:0]          instruction;
  logic                alu_zero;

  logic [7:0]          ir;
  logic [PHASE_W-1:0]  phase;
  logic                busy;

  logic                ir_load;
  logic                pc_inc;
  logic                pc_load;
  logic                alu_en;
  logic                mem_read;
  logic                mem_write;
  logic                reg_write;

  logic                reg_dst;
  logic                alu_src;
  logic                mem_to_reg;
  logic                alu_op;

  logic [RETIRE_W-1:0] retired;

  modport master (
    output step, run, instruction, alu_zero,
    input  ir, phase, busy,
    input  ir_load, pc_inc, pc_load, alu_en, mem_read, mem_write, reg_write,
    input  reg_dst, alu_src, mem_to_reg, alu_op,
    input  retired
  );

  modport slave (
    input  step, run, instruction, alu_zero,
    output ir, phase, busy,
    output ir_load, pc_inc, pc_load, alu_en, mem_read, mem_write, reg_write,
    output reg_dst, alu_src, mem_to_reg, alu_op,
    output retired
  );

endinterface

// File: rtl/instruction_sequencer_decoder.sv
// instruction_decoder: combinational opcode decode.
//   opcode     in  2 : ir[7:6]
//   levels     out   : reg_dst / alu_src / mem_to_reg / alu_op selects
//   last_phase out   : final phase of this opcode's path
module instruction_decoder
  import sequencer_pkg::*;
(
  input  logic [1:0] opcode,
  output levels_t    levels,
  output state_t     last_phase
);

  always_comb begin
    levels     = '0;
    last_phase = S_WRITEBACK;
    case (opcode)
      OP_ADD: begin
        levels.reg_dst = 1'b1;
      end
      OP_LOAD: begin
        levels.alu_src    = 1'b1;
        levels.mem_to_reg = 1'b1;
      end
      OP_STORE: begin
        levels.alu_src = 1'b1;
        last_phase     = S_MEMORY;
      end
      OP_BEQ: begin
        levels.alu_op = 1'b1;
        last_phase    = S_EXECUTE;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: multi-cycle fetch/decode/execute/memory/writeback
// controller for the 8-bit datapath. Advances one phase per step pulse.
//   clock in : system clock (rising edge)
//   clear in : asynchronous active-high reset
//   bus       : slave side of instruction_sequencer_if (step, run,
//               instruction, alu_zero in; ir, phase, busy, strobes,
//               levels, retired out)
//
// state     | meaning
// ----------+-------------------------------------------------
// IDLE      | waiting for step with run=1
// FETCH     | ir just latched, PC advanced
// DECODE    | operands selected
// EXECUTE   | ALU active; BEQ resolves here
// MEMORY    | data memory access (LOAD/STORE only)
// WRITEBACK | register file write (ADD/LOAD only)
module instruction_sequencer
  import sequencer_pkg::*;
#(
  parameter int RETIRE_W = 8
)
(
  input logic                    clock,
  input logic                    clear,
  instruction_sequencer_if.slave bus
);

  state_t              state_q, state_d;
  logic [7:0]          ir_q;
  logic [RETIRE_W-1:0] retired_q;
  logic                complete;

  logic ir_load_d, pc_inc_d, pc_load_d, alu_en_d;
  logic mem_read_d, mem_write_d, reg_write_d;
  logic ir_load_q, pc_inc_q, pc_load_q, alu_en_q;
  logic mem_read_q, mem_write_q, reg_write_q;

  logic [1:0] opcode;
  levels_t    dec_levels;
  state_t     last_phase;
  logic       entering;
  logic       busy;

  assign opcode = ir_q[7:6];

  instruction_decoder u_decoder (
    .opcode     (opcode),
    .levels     (dec_levels),
    .last_phase (last_phase)
  );

  always_comb begin
    state_d   = state_q;
    complete  = 1'b0;
    pc_load_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.step && bus.run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (bus.step) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (bus.step) state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (bus.step) begin
          pc_load_d = (opcode == OP_BEQ) && bus.alu_zero;
          if (last_phase == S_EXECUTE)
            complete = 1'b1;
          else if (opcode == OP_LOAD || opcode == OP_STORE)
            state_d = S_MEMORY;
          else
            state_d = S_WRITEBACK;
        end
      end
      S_MEMORY: begin
        if (bus.step) begin
          if (last_phase == S_MEMORY) complete = 1'b1;
          else                        state_d  = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        if (bus.step) complete = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Completion chains straight into the next fetch while run is held.
    if (complete) state_d = bus.run ? S_FETCH : S_IDLE;

    // No path revisits its own state, so any change of state is an entry.
    entering    = (state_d != state_q);
    ir_load_d   = entering && (state_d == S_FETCH);
    // A taken branch owns the PC in the cycle it would otherwise increment.
    pc_inc_d    = ir_load_d && !pc_load_d;
    alu_en_d    = entering && (state_d == S_EXECUTE);
    mem_read_d  = entering && (state_d == S_MEMORY) && (opcode == OP_LOAD);
    mem_write_d = entering && (state_d == S_MEMORY) && (opcode == OP_STORE);
    reg_write_d = entering && (state_d == S_WRITEBACK);
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q     <= S_IDLE;
      ir_q        <= '0;
      retired_q   <= '0;
      ir_load_q   <= 1'b0;
      pc_inc_q    <= 1'b0;
      pc_load_q   <= 1'b0;
      alu_en_q    <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      reg_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      if (ir_load_d) ir_q <= bus.instruction;
      if (complete)  retired_q <= retired_q + RETIRE_W'(1);
      ir_load_q   <= ir_load_d;
      pc_inc_q    <= pc_inc_d;
      pc_load_q   <= pc_load_d;
      alu_en_q    <= alu_en_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      reg_write_q <= reg_write_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign bus.busy   = busy;
  assign bus.phase  = state_q;
  assign bus.ir     = ir_q;
  assign bus.retired = retired_q;

  assign bus.ir_load   = ir_load_q;
  assign bus.pc_inc    = pc_inc_q;
  assign bus.pc_load   = pc_load_q;
  assign bus.alu_en    = alu_en_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.reg_write = reg_write_q;

  assign bus.reg_dst    = busy && dec_levels.reg_dst;
  assign bus.alu_src    = busy && dec_levels.alu_src;
  assign bus.mem_to_reg = busy && dec_levels.mem_to_reg;
  assign bus.alu_op     = busy && dec_levels.alu_op;

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: self-checking bench for instruction_sequencer.
// A table of instructions is stepped through; each step pushes the
// expected observable state to a queue that is popped and compared one
// cycle later. Hand-written sequences cover clear mid-instruction and
// the retired counter wrap.
module tb_instruction_sequencer;
  import sequencer_pkg::*;

  logic clock = 1'b0;
  logic clear;
  always #5 clock = ~clock;

  instruction_sequencer_if #(.RETIRE_W(8)) bus ();

  instruction_sequencer #(.RETIRE_W(8)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  // strobes packed as {ir_load, pc_inc, pc_load, alu_en, mem_read, mem_write, reg_write}
  localparam logic [6:0] ST_IRL = 7'b1000000;
  localparam logic [6:0] ST_PCI = 7'b0100000;
  localparam logic [6:0] ST_PCL = 7'b0010000;
  localparam logic [6:0] ST_ALU = 7'b0001000;
  localparam logic [6:0] ST_MRD = 7'b0000100;
  localparam logic [6:0] ST_MWR = 7'b0000010;
  localparam logic [6:0] ST_RW  = 7'b0000001;

  typedef struct packed {
    logic [2:0] phase;
    logic       busy;
    logic [6:0] strobes;
    logic [3:0] levels;   // {reg_dst, alu_src, mem_to_reg, alu_op}
    logic [7:0] ir;
    logic [7:0] retired;
  } obs_t;

  typedef struct {
    logic [7:0]      instr;
    logic            zero;
    logic            chain;
    logic            drop_run;
    int              gap;
    int              len;
    logic [4:0][2:0] path;
  } vec_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic obs_t observe();
    obs_t o;
    o.phase   = bus.phase;
    o.busy    = bus.busy;
    o.strobes = {bus.ir_load, bus.pc_inc, bus.pc_load, bus.alu_en,
                 bus.mem_read, bus.mem_write, bus.reg_write};
    o.levels  = {bus.reg_dst, bus.alu_src, bus.mem_to_reg, bus.alu_op};
    o.ir      = bus.ir;
    o.retired = bus.retired;
    return o;
  endfunction

  function automatic logic [3:0] exp_levels(input logic [1:0] op);
    case (op)
      OP_ADD:   return 4'b1000;
      OP_LOAD:  return 4'b0110;
      OP_STORE: return 4'b0100;
      default:  return 4'b0001;
    endcase
  endfunction

  function automatic logic [6:0] strobe_for(input logic [2:0] ph, input logic [1:0] op);
    case (ph)
      3'd1:    return ST_IRL | ST_PCI;
      3'd3:    return ST_ALU;
      3'd4:    return (op == OP_LOAD) ? ST_MRD : ((op == OP_STORE) ? ST_MWR : 7'd0);
      3'd5:    return ST_RW;
      default: return 7'd0;
    endcase
  endfunction

  task automatic check_front(input string name);
    obs_t e, a;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty when output sampled", name);
    end else begin
      e = exp_q.pop_front();
      a = observe();
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got phase=%0d busy=%b strobes=%b levels=%b ir=%h retired=%0d, expected phase=%0d busy=%b strobes=%b levels=%b ir=%h retired=%0d",
                 name, a.phase, a.busy, a.strobes, a.levels, a.ir, a.retired,
                 e.phase, e.busy, e.strobes, e.levels, e.ir, e.retired);
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic do_step, input obs_t e, input string name);
    bus.step = do_step;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    bus.step = 1'b0;
    check_front(name);
  endtask

  task automatic step_expect(input logic [2:0] ph, input logic [6:0] st,
                             input logic [3:0] lv, input logic [7:0] irv,
                             input logic [7:0] rt, input int gap, input string name);
    obs_t e;
    e.phase   = ph;
    e.busy    = (ph != 3'd0);
    e.strobes = st;
    e.levels  = lv;
    e.ir      = irv;
    e.retired = rt;
    cycle(1'b1, e, name);
    e.strobes = 7'd0;
    for (int g = 0; g < gap; g++) cycle(1'b0, e, {name, "_hold"});
  endtask

  task automatic raw_step();
    bus.step = 1'b1;
    @(posedge clock);
    #1;
    bus.step = 1'b0;
  endtask

  vec_t       vecs[7];
  logic [1:0] op, nop;
  logic [7:0] nxt;
  logic [7:0] ret_m;
  logic       pcl;
  logic       in_idle;
  int         pcl_seen;

  initial begin
    vecs[0] = '{8'h1B, 1'b0, 1'b0, 1'b0, 1, 4, {3'd0, 3'd5, 3'd3, 3'd2, 3'd1}};
    vecs[1] = '{8'h46, 1'b0, 1'b0, 1'b0, 0, 5, {3'd5, 3'd4, 3'd3, 3'd2, 3'd1}};
    vecs[2] = '{8'hC0, 1'b1, 1'b1, 1'b0, 1, 3, {3'd0, 3'd0, 3'd3, 3'd2, 3'd1}};
    vecs[3] = '{8'hC0, 1'b0, 1'b0, 1'b0, 0, 3, {3'd0, 3'd0, 3'd3, 3'd2, 3'd1}};
    vecs[4] = '{8'h85, 1'b0, 1'b0, 1'b1, 1, 4, {3'd0, 3'd4, 3'd3, 3'd2, 3'd1}};
    vecs[5] = '{8'h1B, 1'b1, 1'b1, 1'b0, 0, 4, {3'd0, 3'd5, 3'd3, 3'd2, 3'd1}};
    vecs[6] = '{8'h46, 1'b1, 1'b0, 1'b0, 2, 5, {3'd5, 3'd4, 3'd3, 3'd2, 3'd1}};

    bus.step = 1'b0;
    bus.run = 1'b0;
    bus.instruction = 8'h00;
    bus.alu_zero = 1'b0;
    clear = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    // step with run while clear is held must not move the FSM
    bus.run = 1'b1;
    bus.instruction = 8'h5A;
    cycle(1'b1, '0, "step_in_clear");
    bus.run = 1'b0;
    clear = 1'b0;
    cycle(1'b0, '0, "reset_state");
    cycle(1'b1, '0, "idle_step_run0");

    // clear during MEMORY of a LOAD
    bus.run = 1'b1;
    bus.instruction = 8'h46;
    step_expect(3'd1, ST_IRL | ST_PCI, 4'b0110, 8'h46, 8'd0, 0, "ld_fetch");
    step_expect(3'd2, 7'd0, 4'b0110, 8'h46, 8'd0, 0, "ld_decode");
    step_expect(3'd3, ST_ALU, 4'b0110, 8'h46, 8'd0, 0, "ld_execute");
    step_expect(3'd4, ST_MRD, 4'b0110, 8'h46, 8'd0, 0, "ld_memory");
    #2;
    clear = 1'b1;
    #1;
    exp_q.push_back('0);
    check_front("clear_async");
    bus.step = 1'b1;
    @(posedge clock);
    #1;
    bus.step = 1'b0;
    exp_q.push_back('0);
    check_front("clear_held");
    clear = 1'b0;
    bus.run = 1'b0;
    cycle(1'b0, '0, "after_clear");
    cycle(1'b1, '0, "after_clear_step");

    // retired wrap: 256 back-to-back BEQ instructions
    bus.run = 1'b1;
    bus.instruction = 8'hC0;
    bus.alu_zero = 1'b0;
    pcl_seen = 0;
    raw_step();
    for (int n = 0; n < 256; n++) begin
      raw_step();
      raw_step();
      if (n == 255) bus.run = 1'b0;
      raw_step();
      if (bus.pc_load) pcl_seen++;
      if (n == 0)   check("wrap_first", {24'd0, bus.retired}, 32'd1);
      if (n == 254) check("wrap_255", {24'd0, bus.retired}, 32'd255);
    end
    check("wrap_zero", {24'd0, bus.retired}, 32'd0);
    check("wrap_idle", {28'd0, bus.busy, bus.phase}, 32'd0);
    check("wrap_no_pc_load", pcl_seen, 0);

    // table-driven instruction stream
    ret_m = 8'd0;
    in_idle = 1'b1;
    for (int i = 0; i < 7; i++) begin
      op  = vecs[i].instr[7:6];
      nxt = (i < 6) ? vecs[i+1].instr : 8'h3C;
      nop = nxt[7:6];
      bus.alu_zero = vecs[i].zero;
      if (in_idle) begin
        bus.run = 1'b1;
        bus.instruction = vecs[i].instr;
        step_expect(3'd1, ST_IRL | ST_PCI, exp_levels(op), vecs[i].instr,
                    ret_m, vecs[i].gap, "fetch");
      end
      // switches move mid-instruction; ir must hold
      bus.instruction = nxt;
      for (int k = 1; k < vecs[i].len; k++) begin
        if (vecs[i].drop_run && k == 2) bus.run = 1'b0;
        step_expect(vecs[i].path[k], strobe_for(vecs[i].path[k], op), exp_levels(op),
                    vecs[i].instr, ret_m, vecs[i].gap, "phase");
      end
      bus.run = vecs[i].chain;
      pcl = (op == OP_BEQ) && vecs[i].zero;
      ret_m = ret_m + 8'd1;
      if (vecs[i].chain)
        step_expect(3'd1, ST_IRL | (pcl ? ST_PCL : ST_PCI), exp_levels(nop), nxt,
                    ret_m, vecs[i].gap, "chain");
      else
        step_expect(3'd0, pcl ? ST_PCL : 7'd0, 4'd0, vecs[i].instr,
                    ret_m, vecs[i].gap, "complete");
      in_idle = !vecs[i].chain;
    end

    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
